event_proc_sequencer: RTL
=========================

// Module: event_proc_sequencer
// PURPOSE
//  Post-detection scheduler for one acoustic channel. It watches eventDetected from the event FSM.
//  On each event onset it runs the shared processing chain in order:
//  FFT, then the frequency and bandwidth estimators in parallel, then the report transmitter.
//  Each stage uses a start/done handshake with a per-stage timeout. Sits between fsmDing and the
//  FFT/estimator/TX datapath blocks.
// PARAMETERS
//  TMO_W       16     width of stage timeout counter
//  TMO_CYCLES  50000  max cycles a stage may run before abort (1..2**TMO_W-1)
//  CNT_W       16     width of event/overrun/abort counters
//  REPEAT      0      1: re-run chain while event persists; 0: one run per event
// PORTS
//  clock          in   1      system clock
//  reset          in   1      asynchronous, active-low reset
//  eventDetected  in   1      level from event FSM
//  fft_done       in   1      FFT stage finished (1-cycle pulse)
//  freq_done      in   1      frequency estimator finished (pulse)
//  bw_done        in   1      bandwidth estimator finished (pulse)
//  tx_done        in   1      transmitter finished sending report (pulse)
//  clear_err      in   1      clears error flag
//  fft_start      out  1      1-cycle start pulse to FFT
//  est_start      out  1      1-cycle start pulse to both estimators
//  tx_start       out  1      1-cycle start pulse to transmitter
//  busy           out  1      high in FFT/EST/TX states
//  error          out  1      sticky: a stage timed out
//  stage          out  3      current state encoding (debug)
//  event_count    out  CNT_W  accepted event onsets, saturating
//  overrun_count  out  CNT_W  onsets seen while busy (dropped), saturating
//  abort_count    out  CNT_W  stage timeouts, saturating
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE; all outputs 0; counters 0; edge register 0.
//  Onset = eventDetected==1 && registered previous value==0 (one-cycle detect latency).
//  States: IDLE=0, FFT=1, EST=2, TX=3, WAIT_END=4.
//  IDLE: on onset -> FFT; assert fft_start for 1 cycle on entry; event_count++.
//  FFT: fft_done -> EST with est_start pulse on entry; clear freq/bw done latches.
//  EST: latch freq_done and bw_done independently. Either order or the same cycle is allowed.
//       Both latched (including a latch set this cycle) -> TX with tx_start pulse.
//  TX: tx_done -> if REPEAT && eventDetected -> FFT (fft_start pulse); else WAIT_END.
//  WAIT_END: eventDetected==0 -> IDLE; otherwise stay.
//  done inputs: sampled only in the matching state. Ignored in the start-pulse cycle
//       (the stage cannot finish in 0 cycles) and in every other state.
//  Timeout: counter clears on each stage entry and increments each cycle in FFT/EST/TX.
//       If it reaches TMO_CYCLES without completion: error<=1, abort_count++, -> WAIT_END.
//       No start pulse is issued on abort.
//  done and timeout in the same cycle: done wins, no abort.
//  Onset while busy or in WAIT_END: overrun_count++. The onset is not queued.
//  error stays set until clear_err==1. If clear_err and a new timeout occur in the same cycle,
//       error stays 1.
//  All counters saturate at 2**CNT_W-1 and do not wrap.
//  Start pulses are never asserted together. busy = (state inside FFT..TX).
//  Reset mid-operation: immediate return to IDLE. Outputs drop asynchronously.
//       Pending done latches are cleared.
// STRUCTURE
//  Shared package avs_ctrl_pkg: state enum seq_state_t (3 bits), default TMO/CNT widths.
//  Sub-module stage_timer: load/enable counter with terminal-count flag (TMO_W, TMO_CYCLES).
//  FSM, edge detect, done latches and saturating counters stay in this module.
// TESTING
//  Rise eventDetected, fft_done 5 cycles after fft_start, freq then bw 3 cycles apart,
//       tx_done after 10 cycles -> start pulses fire once each in order; WAIT_END; IDLE after fall.
//  freq_done and bw_done in the same cycle -> tx_start exactly 1 cycle later.
//  TMO_CYCLES=8, never assert fft_done -> abort after 8 cycles, error=1, abort_count=1,
//       no est_start; clear_err -> error=0.
//  Drop and re-raise eventDetected during EST -> overrun_count=1; event_count stays 1.
//  REPEAT=1, eventDetected held high -> chain restarts after each tx_done; 3 runs, event_count=1.
//  Assert reset low during TX -> outputs 0 immediately; resume with a new onset after reset.

Source files
------------

// File: rtl/avs_ctrl_pkg.sv
// avs_ctrl_pkg: shared sequencer state encoding and default widths
package avs_ctrl_pkg;
  localparam int TMO_W_DEF = 16;
  localparam int TMO_CYCLES_DEF = 50000;
  localparam int CNT_W_DEF = 16;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FFT = 3'd1;
  localparam logic [2:0] ST_EST = 3'd2;
  localparam logic [2:0] ST_TX = 3'd3;
  localparam logic [2:0] ST_WAIT_END = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_FFT = ST_FFT,
    S_EST = ST_EST,
    S_TX = ST_TX,
    S_WAIT_END = ST_WAIT_END
  } seq_state_t;
endpackage

// File: rtl/stage_timer.sv
// stage_timer: per-stage cycle counter; tc marks the last allowed cycle of a stage
module stage_timer
  import avs_ctrl_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);
  logic [TMO_W-1:0] count;
  assign tc = count == TMO_W'(TMO_CYCLES - 1);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count <= '0;
    else if (load) count <= '0;
    else if (en && !tc) count <= count + TMO_W'(1);
  end
endmodule

// File: rtl/event_proc_sequencer.sv
// event_proc_sequencer: runs FFT -> estimators -> TX once per event onset, with per-stage timeout
module event_proc_sequencer
  import avs_ctrl_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter bit REPEAT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             eventDetected,
  input  logic             fft_done,
  input  logic             freq_done,
  input  logic             bw_done,
  input  logic             tx_done,
  input  logic             clear_err,
  output logic             fft_start,
  output logic             est_start,
  output logic             tx_start,
  output logic             busy,
  output logic             error,
  output logic [2:0]       stage,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] overrun_count,
  output logic [CNT_W-1:0] abort_count
);
  seq_state_t state, nxt;
  logic prev_evt, onset, first, freq_l, bw_l, freq_ok, bw_ok, stage_done, abort, enter, tc;
  assign onset = eventDetected && !prev_evt;
  // the start-pulse cycle is the stage entry cycle, where done inputs are ignored
  assign first = fft_start || est_start || tx_start;
  assign busy = state inside {S_FFT, S_EST, S_TX};
  assign stage = state;
  assign freq_ok = freq_l || (freq_done && !first);
  assign bw_ok = bw_l || (bw_done && !first);
  assign stage_done = !first && (state == S_FFT ? fft_done :
                                 state == S_EST ? freq_ok && bw_ok :
                                 state == S_TX && tx_done);
  assign abort = busy && tc && !stage_done;
  assign enter = nxt != state && nxt inside {S_FFT, S_EST, S_TX};
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     nxt = onset ? S_FFT : S_IDLE;
      S_FFT:      nxt = stage_done ? S_EST : abort ? S_WAIT_END : S_FFT;
      S_EST:      nxt = stage_done ? S_TX : abort ? S_WAIT_END : S_EST;
      S_TX:       nxt = stage_done ? (REPEAT && eventDetected ? S_FFT : S_WAIT_END) :
                        abort ? S_WAIT_END : S_TX;
      S_WAIT_END: nxt = eventDetected ? S_WAIT_END : S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end
  stage_timer #(.TMO_W(TMO_W), .TMO_CYCLES(TMO_CYCLES)) u_timer (
    .clock(clock),
    .reset(reset),
    .load(enter),
    .en(busy),
    .tc(tc)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      prev_evt <= 1'b0;
      fft_start <= 1'b0;
      est_start <= 1'b0;
      tx_start <= 1'b0;
      freq_l <= 1'b0;
      bw_l <= 1'b0;
      error <= 1'b0;
      event_count <= '0;
      overrun_count <= '0;
      abort_count <= '0;
    end else begin
      state <= nxt;
      prev_evt <= eventDetected;
      fft_start <= enter && nxt == S_FFT;
      est_start <= enter && nxt == S_EST;
      tx_start <= enter && nxt == S_TX;
      freq_l <= state == S_EST && freq_ok;
      bw_l <= state == S_EST && bw_ok;
      error <= abort || (error && !clear_err);
      if (onset && state == S_IDLE && !(&event_count)) event_count <= event_count + CNT_W'(1);
      if (onset && state != S_IDLE && !(&overrun_count)) overrun_count <= overrun_count + CNT_W'(1);
      if (abort && !(&abort_count)) abort_count <= abort_count + CNT_W'(1);
    end
  end
endmodule
